// File: rtl/bf8b_mem_pkg.sv
// Shared types and default widths for the memory-bus client.
package bf8b_mem_pkg;

    localparam int unsigned MC_ADDR_W = 8;
    localparam int unsigned MC_DATA_W = 8;

    // Client handshake state: idle, request outstanding, waiting for ready to fall.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        RELEASE = 2'd2
    } mc_state_t;

endpackage

// File: rtl/mem_client_fifo.sv
// Command FIFO for mem_client: synchronous, registered full flag, head read from
// the storage registers at the read pointer.
module mem_client_fifo #(
    parameter int unsigned WIDTH = 17,
    parameter int unsigned DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]    count_q, count_d;
    logic             full_q;
    logic             do_push, do_pop;

    // A push while full is dropped; a pop while empty is ignored.
    assign do_push = push & ~full_q;
    assign do_pop  = pop & ~empty;

    assign full  = full_q;
    assign empty = (count_q == '0);
    assign head  = mem_q[rd_ptr_q];

    // Occupancy update; simultaneous push and pop leave the count unchanged.
    always_comb begin
        count_d = count_q;
        unique case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointers and count; full is registered from the next count so it has no bypass.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
            count_q <= count_d;
            full_q  <= (count_d == CW'(DEPTH));
        end
    end

    // Storage needs no reset: entries are only read after being written.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/mem_client.sv
// Client port for the shared memory bus arbiter: queues commands, runs the 4-phase
// request/ready handshake on one arbiter slot and returns one response per command.
module mem_client
    import bf8b_mem_pkg::*;
#(
    parameter int unsigned ADDR_W  = MC_ADDR_W,
    parameter int unsigned DATA_W  = MC_DATA_W,
    parameter int unsigned DEPTH   = 2,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic              cmd_we,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_we,
    output logic              busy,
    output logic              err,
    output logic              request,
    output logic [ADDR_W-1:0] addr,
    output logic              we,
    output logic [DATA_W-1:0] data_out,
    input  logic              ready,
    input  logic [DATA_W-1:0] data_in
);

    localparam int unsigned CMD_W = ADDR_W + DATA_W + 1;
    localparam int unsigned TW    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT);

    mc_state_t         state_q, state_d;
    logic              request_q, request_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              we_q, we_d;
    logic [DATA_W-1:0] data_out_q, data_out_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
    logic              rsp_we_q, rsp_we_d;
    logic              err_q, err_d;
    logic [TW-1:0]     tmo_cnt_q, tmo_cnt_d;

    logic              fifo_full, fifo_empty, fifo_pop;
    logic [CMD_W-1:0]  fifo_head;

    mem_client_fifo #(
        .WIDTH (CMD_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (cmd_valid),
        .wdata ({cmd_we, cmd_addr, cmd_wdata}),
        .pop   (fifo_pop),
        .full  (fifo_full),
        .empty (fifo_empty),
        .head  (fifo_head)
    );

    assign cmd_ready = ~fifo_full;
    assign busy      = ~fifo_empty | (state_q != IDLE);
    assign request   = request_q;
    assign addr      = addr_q;
    assign we        = we_q;
    assign data_out  = data_out_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_we    = rsp_we_q;
    assign err       = err_q;

    // Handshake sequencing, bus register loads, response capture and timeout.
    always_comb begin
        state_d     = state_q;
        request_d   = request_q;
        addr_d      = addr_q;
        we_d        = we_q;
        data_out_d  = data_out_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        rsp_we_d    = rsp_we_q;
        err_d       = err_q;
        tmo_cnt_d   = '0;
        fifo_pop    = 1'b0;
        unique case (state_q)
            IDLE: begin
                // Waiting for ready low also keeps us quiet if reset hit mid-transfer.
                if (!fifo_empty && !ready) begin
                    {we_d, addr_d, data_out_d} = fifo_head;
                    request_d = 1'b1;
                    fifo_pop  = 1'b1;
                    state_d   = REQ;
                end
            end
            REQ: begin
                if (ready) begin
                    rsp_rdata_d = data_in;
                    rsp_we_d    = we_q;
                    rsp_valid_d = 1'b1;
                    request_d   = 1'b0;
                    we_d        = 1'b0;
                    state_d     = RELEASE;
                end else if (TIMEOUT != 0) begin
                    // Saturating count; the transfer keeps waiting after err sets.
                    tmo_cnt_d = (tmo_cnt_q != TMO_MAX) ? tmo_cnt_q + TW'(1) : tmo_cnt_q;
                    if (tmo_cnt_d == TMO_MAX) err_d = 1'b1;
                end
            end
            RELEASE: begin
                if (!ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and registered bus/response outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            request_q   <= 1'b0;
            addr_q      <= '0;
            we_q        <= 1'b0;
            data_out_q  <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_we_q    <= 1'b0;
            err_q       <= 1'b0;
            tmo_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            request_q   <= request_d;
            addr_q      <= addr_d;
            we_q        <= we_d;
            data_out_q  <= data_out_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_we_q    <= rsp_we_d;
            err_q       <= err_d;
            tmo_cnt_q   <= tmo_cnt_d;
        end
    end

endmodule

// File: tb/tb_mem_client.sv
// Bench for mem_client: arbiter/memory model, in-order scoreboard and rule checks,
// directed scenarios followed by randomized command streams.
module tb_mem_client;

    localparam int unsigned ADDR_W  = 8;
    localparam int unsigned DATA_W  = 8;
    localparam int unsigned DEPTH   = 2;
    localparam int unsigned TIMEOUT = 255;

    localparam int BUS_NORMAL = 0;
    localparam int BUS_HOLD   = 1;
    localparam int BUS_HIGH   = 2;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              cmd_valid = 1'b0;
    logic              cmd_ready;
    logic [ADDR_W-1:0] cmd_addr = '0;
    logic              cmd_we = 1'b0;
    logic [DATA_W-1:0] cmd_wdata = '0;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_we;
    logic              busy;
    logic              err;
    logic              request;
    logic [ADDR_W-1:0] addr;
    logic              we;
    logic [DATA_W-1:0] data_out;
    logic              ready = 1'b0;
    logic [DATA_W-1:0] data_in = '0;

    always #5 clk = ~clk;

    mem_client #(
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .DEPTH   (DEPTH),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_addr  (cmd_addr),
        .cmd_we    (cmd_we),
        .cmd_wdata (cmd_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_we    (rsp_we),
        .busy      (busy),
        .err       (err),
        .request   (request),
        .addr      (addr),
        .we        (we),
        .data_out  (data_out),
        .ready     (ready),
        .data_in   (data_in)
    );

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic              we;
        logic [DATA_W-1:0] wdata;
        logic [DATA_W-1:0] rdata;
    } cmd_t;

    cmd_t stim_q[$];  // not yet offered/taken
    cmd_t acc_q[$];   // accepted, still in the FIFO
    cmd_t iss_q[$];   // on the bus

    logic [DATA_W-1:0] ref_mem [256];
    logic [DATA_W-1:0] bus_mem [256];

    int n_checks = 0;
    int n_errors = 0;

    int bus_mode = BUS_NORMAL;
    int rel_delay = 1;
    bit rand_rel = 1'b0;
    int hi_cnt = 0;
    int lo_cnt = 0;
    int vprob = 100;

    bit req_prev = 1'b0;
    bit err_prev = 1'b0;
    bit err_exp = 1'b0;
    bit in_release = 1'b0;
    bit need_low = 1'b0;
    int low_edges = 0;
    int age = 0;
    int step_no = 0;
    int acc_step = 0;
    int rise_step = 0;
    int err_rise_step = 0;
    int rsp_count = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic add_cmd(input logic [ADDR_W-1:0] a, input logic w, input logic [DATA_W-1:0] d);
        cmd_t c;
        c.addr = a;
        c.we = w;
        c.wdata = d;
        c.rdata = '0;
        stim_q.push_back(c);
    endtask

    task automatic set_bus(input int mode);
        bus_mode = mode;
        hi_cnt = 0;
        lo_cnt = 0;
    endtask

    // One cycle: check outputs at the negedge, then advance the bus model and driver.
    task automatic step();
        cmd_t c;
        bit   rdy_s;
        @(negedge clk);
        step_no++;
        rdy_s = ready;  // the value the DUT sampled at the last posedge

        // A response follows exactly the edge where ready is seen high during a request.
        check("rsp_timing", rsp_valid, req_prev && rdy_s);
        if (rsp_valid) begin
            if (iss_q.size() == 0) begin
                check("rsp_spurious", iss_q.size(), 1);
            end else begin
                c = iss_q.pop_front();
                check("rsp_we", rsp_we, c.we);
                if (!c.we) check("rsp_rdata", rsp_rdata, c.rdata);
                rsp_count++;
                in_release = 1'b1;
            end
        end else if (in_release && !rdy_s) begin
            in_release = 1'b0;
        end

        if (need_low && !rdy_s) low_edges++;
        if (!request && req_prev) begin
            need_low = 1'b1;
            low_edges = 0;
        end

        if (request && !req_prev) begin
            check("rise_ready_low", rdy_s, 1'b0);
            // After a transfer, ready must be seen low once before the next load edge.
            if (need_low) check("rise_after_release", low_edges >= 2, 1'b1);
            need_low = 1'b0;
            if (acc_q.size() == 0) check("rise_empty", acc_q.size(), 1);
            else iss_q.push_back(acc_q.pop_front());
            rise_step = step_no;
            age = 0;
        end

        if (request) begin
            age++;
            if (TIMEOUT != 0 && age == int'(TIMEOUT) + 1) err_exp = 1'b1;
            if (iss_q.size() > 0) begin
                c = iss_q[0];
                check("bus_addr", addr, c.addr);
                check("bus_we", we, c.we);
                check("bus_data", data_out, c.wdata);
            end
        end else begin
            age = 0;
        end

        if (err && !err_prev) err_rise_step = step_no;
        err_prev = err;
        check("err", err, err_exp);
        check("cmd_ready", cmd_ready, acc_q.size() < int'(DEPTH));
        check("busy", busy, acc_q.size() > 0 || iss_q.size() > 0 || in_release);
        req_prev = request;

        // Arbiter model: ready 2 cycles after request, drops rel_delay after request falls.
        if (bus_mode == BUS_HOLD) begin
            ready = 1'b0;
            hi_cnt = 0;
        end else if (bus_mode == BUS_HIGH) begin
            ready = 1'b1;
        end else if (!ready) begin
            if (request) begin
                hi_cnt++;
                if (hi_cnt >= 2) begin
                    ready = 1'b1;
                    hi_cnt = 0;
                    lo_cnt = 0;
                    if (we) bus_mem[addr] = data_out;
                end
            end else begin
                hi_cnt = 0;
            end
        end else if (!request) begin
            lo_cnt++;
            if (lo_cnt >= rel_delay) begin
                ready = 1'b0;
                lo_cnt = 0;
                if (rand_rel) rel_delay = int'($urandom_range(1, 3));
            end
        end
        data_in = bus_mem[addr];

        // Command driver; the reference memory is updated in acceptance order.
        if (rst && stim_q.size() > 0 && $urandom_range(0, 99) < vprob) begin
            c = stim_q[0];
            cmd_valid = 1'b1;
            cmd_addr = c.addr;
            cmd_we = c.we;
            cmd_wdata = c.wdata;
            if (cmd_ready) begin
                c = stim_q.pop_front();
                if (c.we) ref_mem[c.addr] = c.wdata;
                else c.rdata = ref_mem[c.addr];
                acc_q.push_back(c);
                acc_step = step_no;
            end
        end else begin
            cmd_valid = 1'b0;
            cmd_addr = ADDR_W'($urandom);
            cmd_we = 1'($urandom);
            cmd_wdata = DATA_W'($urandom);
        end
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while ((stim_q.size() + acc_q.size() + iss_q.size() != 0 || in_release || ready)
               && n < budget) begin
            step();
            n++;
        end
        check("drain", stim_q.size() + acc_q.size() + iss_q.size(), 0);
        step();
    endtask

    // Asynchronous reset from the current point; flushed commands never reach memory.
    task automatic do_reset();
        rst = 1'b0;
        cmd_valid = 1'b0;
        #1;
        check("rst_request", request, 1'b0);
        check("rst_rsp_valid", rsp_valid, 1'b0);
        check("rst_err", err, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_cmd_ready", cmd_ready, 1'b1);
        check("rst_addr", addr, 0);
        check("rst_we", we, 1'b0);
        check("rst_data_out", data_out, 0);
        check("rst_rsp_rdata", rsp_rdata, 0);
        check("rst_rsp_we", rsp_we, 1'b0);
        stim_q.delete();
        acc_q.delete();
        iss_q.delete();
        for (int i = 0; i < 256; i++) ref_mem[i] = bus_mem[i];
        req_prev = 1'b0;
        err_prev = 1'b0;
        err_exp = 1'b0;
        in_release = 1'b0;
        need_low = 1'b0;
        age = 0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        int base;
        int n;
        for (int i = 0; i < 256; i++) begin
            bus_mem[i] = DATA_W'($urandom);
            ref_mem[i] = bus_mem[i];
        end
        bus_mem[8'h10] = 8'hA5;
        ref_mem[8'h10] = 8'hA5;

        @(negedge clk);
        do_reset();

        // Read
        base = rsp_count;
        rise_step = -100;
        add_cmd(8'h10, 1'b0, 8'h77);
        drain(50);
        check("t1_latency", rise_step - acc_step, 2);
        check("t1_rsp_count", rsp_count - base, 1);
        check("t1_rdata", rsp_rdata, 8'hA5);
        check("t1_rsp_we", rsp_we, 1'b0);
        check("t1_busy", busy, 1'b0);

        // Write
        base = rsp_count;
        add_cmd(8'h20, 1'b1, 8'h3C);
        drain(50);
        check("t2_mem", bus_mem[8'h20], 8'h3C);
        check("t2_rsp_we", rsp_we, 1'b1);
        check("t2_rsp_count", rsp_count - base, 1);

        // Full: one command leaves the FIFO for the bus, so the fourth is refused.
        base = rsp_count;
        set_bus(BUS_HOLD);
        add_cmd(8'h30, 1'b1, 8'h11);
        add_cmd(8'h30, 1'b0, 8'h00);
        add_cmd(8'h31, 1'b1, 8'h22);
        add_cmd(8'h31, 1'b0, 8'h00);
        for (int i = 0; i < 12; i++) step();
        check("t3_full", cmd_ready, 1'b0);
        check("t3_not_taken", stim_q.size(), 1);
        set_bus(BUS_NORMAL);
        drain(100);
        check("t3_rsp_count", rsp_count - base, 4);

        // Slow release
        base = rsp_count;
        rel_delay = 3;
        add_cmd(8'h40, 1'b1, 8'h5A);
        add_cmd(8'h40, 1'b0, 8'h00);
        drain(100);
        check("t5_rsp_count", rsp_count - base, 2);
        check("t5_rdata", rsp_rdata, 8'h5A);
        rel_delay = 1;

        // Timeout
        set_bus(BUS_HOLD);
        add_cmd(8'h50, 1'b0, 8'h00);
        for (int i = 0; i < 300; i++) step();
        check("t4_err", err, 1'b1);
        check("t4_request", request, 1'b1);
        check("t4_err_delay", err_rise_step - rise_step, TIMEOUT);
        set_bus(BUS_NORMAL);
        drain(50);
        check("t4_err_sticky", err, 1'b1);

        // Reset while requesting, with ready then held high
        set_bus(BUS_HOLD);
        add_cmd(8'h60, 1'b0, 8'h00);
        n = 0;
        while (!request && n < 20) begin
            step();
            n++;
        end
        check("t6_in_req", request, 1'b1);
        set_bus(BUS_HIGH);
        ready = 1'b1;
        do_reset();
        add_cmd(8'h61, 1'b0, 8'h00);
        for (int i = 0; i < 6; i++) begin
            step();
            check("t6_req_low", request, 1'b0);
        end
        set_bus(BUS_NORMAL);
        drain(50);
        check("t6_rdata", rsp_rdata, ref_mem[8'h61]);

        // Randomized streams with varying offer rate and release delay
        rand_rel = 1'b1;
        for (int b = 0; b < 3; b++) begin
            base = rsp_count;
            vprob = (b == 0) ? 100 : ((b == 1) ? 50 : 20);
            for (int i = 0; i < 50; i++) begin
                add_cmd(ADDR_W'($urandom_range(0, 7)), 1'($urandom), DATA_W'($urandom));
            end
            drain(3000);
            check("rand_rsp_count", rsp_count - base, 50);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
